systolic_array_sequencer: RTL and testbench

//  Sequences one pass of the SYSTOLIC_SIZE x SYSTOLIC_SIZE weight-stationary systolic array.
//  - Loads weights by scan shifting.
//  - Streams a block of activation vectors with per-row skew.
//  - Drains the array and flags per-column partial-sum validity.

---
 rtl/systolic_array_sequencer.sv | 159 +++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sequencer.sv
// Weight-stationary systolic array pass sequencer: weight scan-load, skewed activation feed, drain.
// Optional macro SEQ_FAULT_BYPASS_EN adds pe_disable_cfg and drives PE_disable during a pass.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | scan-shifting weight rows, bottom row first
// FEED   | streaming skewed activations, t = 0 .. N+S-2
// DRAIN  | flushing partial sums, t = N+S-1 .. N+2S-2
// DONE   | one-cycle completion pulse
module systolic_array_sequencer #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int VEC_CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [VEC_CNT_WIDTH-1:0]         num_vec,
    input  logic                             abort,
`ifdef SEQ_FAULT_BYPASS_EN
    input  logic [SYSTOLIC_SIZE-1:0]         pe_disable_cfg,
`endif
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic                             scan_en,
    output logic                             w_rd_en,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] w_rd_addr,
    output logic [SYSTOLIC_SIZE-1:0]         act_row_en,
    output logic [SYSTOLIC_SIZE-1:0]         psum_col_valid,
    output logic [SYSTOLIC_SIZE-1:0]         PE_disable
);
    localparam int AW = $clog2(SYSTOLIC_SIZE);
    localparam int TW = VEC_CNT_WIDTH + AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic [TW-1:0]            t_q, t_d;
    logic [VEC_CNT_WIDTH-1:0] n_q, n_d;
    logic [SYSTOLIC_SIZE-1:0] pe_q, pe_d;
    logic [TW-1:0]            n_ext, feed_last, drain_last;

    logic                     busy_d, done_d, cfg_err_d, scan_en_d;
    logic [AW-1:0]            w_rd_addr_d;
    logic [SYSTOLIC_SIZE-1:0] act_d, psum_d, pe_dis_d;

    assign feed_last  = TW'(n_q) + TW'(SYSTOLIC_SIZE - 2);
    assign drain_last = TW'(n_q) + TW'(2 * SYSTOLIC_SIZE - 2);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        n_d       = n_q;
        pe_d      = pe_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        state_d = S_LOAD_W;
                        k_d     = '0;
                        n_d     = num_vec;
`ifdef SEQ_FAULT_BYPASS_EN
                        pe_d    = pe_disable_cfg;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (k_q == AW'(SYSTOLIC_SIZE - 1)) begin
                    state_d = S_FEED;
                    t_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_FEED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    t_d = t_q + TW'(1);
                    if (t_q == feed_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (t_q == drain_last) begin
                    state_d = S_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop (Moore, registered).
    always_comb begin
        n_ext       = TW'(n_d);
        busy_d      = (state_d == S_LOAD_W) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        scan_en_d   = (state_d == S_LOAD_W);
        w_rd_addr_d = scan_en_d ? (AW'(SYSTOLIC_SIZE - 1) - k_d) : '0;
        act_d       = '0;
        psum_d      = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            act_d[i]  = (state_d == S_FEED) && (t_d >= TW'(i)) && (t_d < TW'(i) + n_ext);
            psum_d[i] = ((state_d == S_FEED) || (state_d == S_DRAIN)) &&
                        (t_d >= TW'(SYSTOLIC_SIZE + i)) && (t_d < TW'(SYSTOLIC_SIZE + i) + n_ext);
        end
`ifdef SEQ_FAULT_BYPASS_EN
        pe_dis_d = busy_d ? pe_d : '0;
`else
        pe_dis_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            t_q            <= '0;
            n_q            <= '0;
            pe_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            scan_en        <= 1'b0;
            w_rd_en        <= 1'b0;
            w_rd_addr      <= '0;
            act_row_en     <= '0;
            psum_col_valid <= '0;
            PE_disable     <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            t_q            <= t_d;
            n_q            <= n_d;
            pe_q           <= pe_d;
            busy           <= busy_d;
            done           <= done_d;
            cfg_err        <= cfg_err_d;
            scan_en        <= scan_en_d;
            w_rd_en        <= scan_en_d;
            w_rd_addr      <= w_rd_addr_d;
            act_row_en     <= act_d;
            psum_col_valid <= psum_d;
            PE_disable     <= pe_dis_d;
        end
    end
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench for systolic_array_sequencer: directed scenarios plus randomized traffic
// compared against a pass-timeline reference model (cycle offset from the accepted start).
module tb_systolic_array_sequencer;
    localparam int S  = 8;
    localparam int VW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] num_vec;
    logic          abort;
    logic [S-1:0]  pe_cfg;
    logic          busy, done, cfg_err, scan_en, w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [S-1:0]  act_row_en, psum_col_valid, PE_disable;

    systolic_array_sequencer #(.SYSTOLIC_SIZE(S), .VEC_CNT_WIDTH(VW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vec        (num_vec),
        .abort          (abort),
`ifdef SEQ_FAULT_BYPASS_EN
        .pe_disable_cfg (pe_cfg),
`endif
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .scan_en        (scan_en),
        .w_rd_en        (w_rd_en),
        .w_rd_addr      (w_rd_addr),
        .act_row_en     (act_row_en),
        .psum_col_valid (psum_col_valid),
        .PE_disable     (PE_disable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a pass is described only by its start cycle, N and latched mask.
    bit           m_active  = 1'b0;
    int           m_c0      = 0;
    int           m_n       = 0;
    int           m_err_cyc = -1;
    logic [S-1:0] m_cfg     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic          e_busy, e_done, e_err, e_scan;
        logic [AW-1:0] e_addr;
        logic [S-1:0]  e_act, e_psum, e_pe;
        int d, t;
        e_busy = 0; e_done = 0; e_scan = 0; e_addr = '0;
        e_act = '0; e_psum = '0; e_pe = '0;
        if (m_active) begin
            d = cyc - m_c0;
            if (d >= 1 && d <= S) begin
                e_busy = 1; e_scan = 1; e_addr = AW'(S - d); e_pe = m_cfg;
            end else if (d >= S + 1 && d <= m_n + 3 * S - 1) begin
                t = d - S - 1;
                e_busy = 1; e_pe = m_cfg;
                for (int i = 0; i < S; i++) begin
                    e_act[i]  = (t <= m_n + S - 2) && (t >= i) && (t < i + m_n);
                    e_psum[i] = (t >= S + i) && (t < S + i + m_n);
                end
            end else if (d == m_n + 3 * S) begin
                e_done = 1;
            end
        end
`ifndef SEQ_FAULT_BYPASS_EN
        e_pe = '0;
`endif
        e_err = (cyc == m_err_cyc);
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
        check("scan_en", 32'(scan_en), 32'(e_scan));
        check("w_rd_en", 32'(w_rd_en), 32'(e_scan));
        check("w_rd_addr", 32'(w_rd_addr), 32'(e_addr));
        check("act_row_en", 32'(act_row_en), 32'(e_act));
        check("psum_col_valid", 32'(psum_col_valid), 32'(e_psum));
        check("PE_disable", 32'(PE_disable), 32'(e_pe));
    endtask

    // Called at a negedge: check this cycle, apply inputs, advance the model across the edge.
    task automatic step(input bit st, input logic [VW-1:0] nv, input bit ab, input logic [S-1:0] cfg);
        int d;
        check_outputs();
        start = st; num_vec = nv; abort = ab; pe_cfg = cfg;
        d = cyc - m_c0;
        if (!m_active) begin
            if (st) begin
                if (nv != '0) begin
                    m_active = 1; m_c0 = cyc; m_n = int'(nv); m_cfg = cfg;
                end else begin
                    m_err_cyc = cyc + 1;
                end
            end
        end else if (d >= m_n + 3 * S) begin
            m_active = 0;
        end else if (ab) begin
            m_active = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [S-1:0] cfg);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, cfg);
    endtask

    initial begin
        bit           st, ab;
        logic [VW-1:0] nv;
        rst = 1'b1; start = 0; num_vec = '0; abort = 0; pe_cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the middle of weight loading clears outputs at once.
        step(1'b1, 8'd4, 1'b0, 8'h3C);
        idle(3, 8'h3C);
        check_outputs();
        rst = 1'b1;
        #1;
        m_active = 0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_scan_en", 32'(scan_en), 32'd0);
        check("rst_w_rd_addr", 32'(w_rd_addr), 32'd0);
        check("rst_PE_disable", 32'(PE_disable), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        idle(2, '0);

        // N=4 pass; a second start while busy is ignored; mask changes mid-FEED.
        step(1'b1, 8'd4, 1'b0, 8'h81);
        idle(4, 8'h81);
        step(1'b1, 8'd9, 1'b0, 8'h81);
        idle(8, 8'h81);
        idle(22, 8'hFF);

        // N=1 pass.
        step(1'b1, 8'd1, 1'b0, 8'h42);
        idle(28, 8'h42);

        // Zero-length request.
        step(1'b1, 8'd0, 1'b0, 8'h00);
        idle(3, '0);

        // Abort at FEED t=3 then an immediate N=2 pass.
        step(1'b1, 8'd4, 1'b0, 8'h18);
        idle(S + 3, 8'h18);
        step(1'b0, 8'd0, 1'b1, 8'h18);
        step(1'b1, 8'd2, 1'b0, 8'h24);
        idle(30, 8'h24);

        // Maximum-length pass.
        step(1'b1, 8'd255, 1'b0, 8'h01);
        idle(255 + 3 * S + 2, 8'h01);

        for (int n = 0; n < 4000; n++) begin
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0)       nv = '0;
            else if ($urandom_range(0, 49) == 0) nv = VW'($urandom_range(1, 255));
            else                                 nv = VW'($urandom_range(1, 12));
            step(st, nv, ab, S'($urandom));
        end
        idle(3 * S + 260, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
